msx_ce_gen: RTL

//  Clock-enable generator upstream of the msx core. From the single 21.477 MHz clk21m it derives the

---
 rtl/msx_clk_pkg.sv | 10 +
 rtl/ce_divider.sv | 28 ++
 rtl/msx_ce_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/msx_clk_pkg.sv
// Shared clock constants and the pause FSM state type for the msx clock-enable generator.
package msx_clk_pkg;

   localparam int CLK21M_HZ       = 21477270;
   localparam int RTC_DIV_DEFAULT = CLK21M_HZ / 10;
   localparam int CPU_DIV_DEFAULT = 6;

   typedef enum logic {CE_RUN, CE_PAUSE} ce_state_t;

endpackage

// File: rtl/ce_divider.sv
// Wrapping 0..DIV-1 counter with a registered one-cycle terminal-count strobe.
// The strobe is high after the edge on which the counter held DIV-1.
module ce_divider #(
   parameter int DIV = 4
) (
   input  logic clk21m,
   input  logic reset,
   output logic tc
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   // Count up, wrap at DIV-1 and flag the wrap one cycle wide.
   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         tc  <= 1'b0;
      end else begin
         tc <= (cnt == LAST);
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/msx_ce_gen.sv
// Clock-enable generator for the msx core. All strobes are derived from clk21m,
// are registered and exactly one cycle wide. The pause handshake stops only the
// CPU/PSG enables (ce_3m58_p/n) and only on a whole 3.58 MHz cycle boundary;
// video and RTC enables keep running.
//
// Handshake: pause_req is a level held by the requester until pause_ack equals
// it. Both are sampled/updated only on the P-boundary edge (cnt6 == CPU_DIV-1);
// a pause suppresses that edge's ce_3m58_p, a resume issues it, so the CPU only
// ever sees complete P/N pairs and the last enable before a pause is ce_3m58_n.
module msx_ce_gen
   import msx_clk_pkg::*;
#(
   parameter int RTC_DIV = RTC_DIV_DEFAULT,
   parameter int CPU_DIV = CPU_DIV_DEFAULT
) (
   input  logic      clk21m,
   input  logic      reset,
   input  logic      pause_req,
   output logic      pause_ack,
   output logic      ce_10m7_p,
   output logic      ce_5m39_n,
   output logic      ce_3m58_p,
   output logic      ce_3m58_n,
   output logic      ce_10hz,
   output ce_state_t pause_state
);

   localparam int CW = $clog2(CPU_DIV);
   localparam logic [CW-1:0] P_LAST = CW'(CPU_DIV - 1);
   localparam logic [CW-1:0] N_LAST = CW'(CPU_DIV / 2 - 1);

   logic [CW-1:0] cnt6;
   ce_state_t     state;
   logic          boundary;
   logic          cpu_run;

   assign boundary    = (cnt6 == P_LAST);
   assign cpu_run     = (state == CE_RUN);
   assign pause_state = state;

   // CPU phase counter; its LSB gives the 10.7 MHz strobe so P always lands on one.
   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         cnt6      <= '0;
         ce_10m7_p <= 1'b0;
      end else begin
         ce_10m7_p <= cnt6[0];
         if (boundary) cnt6 <= '0;
         else          cnt6 <= cnt6 + CW'(1);
      end
   end

   // Pause FSM and CPU strobes; state only moves on the P boundary.
   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         state     <= CE_RUN;
         pause_ack <= 1'b0;
         ce_3m58_p <= 1'b0;
         ce_3m58_n <= 1'b0;
      end else begin
         ce_3m58_p <= 1'b0;
         ce_3m58_n <= (cnt6 == N_LAST) && cpu_run;
         if (boundary) begin
            case (state)
               CE_RUN: begin
                  if (pause_req) begin
                     state     <= CE_PAUSE;
                     pause_ack <= 1'b1;
                  end else begin
                     ce_3m58_p <= 1'b1;
                  end
               end
               CE_PAUSE: begin
                  if (!pause_req) begin
                     state     <= CE_RUN;
                     pause_ack <= 1'b0;
                     ce_3m58_p <= 1'b1;
                  end
               end
               default: begin
                  state     <= CE_RUN;
                  pause_ack <= 1'b0;
               end
            endcase
         end
      end
   end

   // Pixel enable: free-running divide-by-4, unrelated to the CPU phase.
   ce_divider #(.DIV(4)) u_div_5m39 (
      .clk21m (clk21m),
      .reset  (reset),
      .tc     (ce_5m39_n)
   );

   // RTC tick: never gated by pause.
   ce_divider #(.DIV(RTC_DIV)) u_div_rtc (
      .clk21m (clk21m),
      .reset  (reset),
      .tc     (ce_10hz)
   );

endmodule
